vga_sync: RTL and testbench

- Generates the 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock.
- Outputs the pixel coordinate (x, y) and video_on consumed by the pong graphics and text generators, plus the hsync/vsync pins to the connector.
- Produces a 25 MHz pixel-enable (p_tick) and a one-clock end-of-frame pulse (frame_tick) for game-logic pacing.

---
 rtl/vga_sync.sv | 111 +++++++++++
 tb/tb_vga_sync.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// vga_sync: 640x480 @ 60 Hz VGA raster timing generator.
// A clock divider produces the pixel enable (p_tick); x/y raster counters
// advance on it. hsync/vsync/frame_tick are registered so they move on the
// same edge as the coordinate they describe. video_on is a pure decode of
// the registered coordinates, gated by reset.
// CLK_DIV is legal over 2..16 (the divider is 4 bits wide).
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic       p_tick_q, p_tick_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;
  logic       x_wrap;
  logic       y_wrap;

  // Pixel divider: p_tick is high for the whole cycle in which div_cnt sits
  // at its terminal value, so the counters step on the edge that ends it.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_MAX) ? 4'd0 : div_cnt_q + 4'd1;
    p_tick_d  = (div_cnt_d == DIV_MAX);
  end

  // Raster counters: x steps on every pixel enable, y on the line wrap.
  always_comb begin
    x_wrap       = (x_q == X_MAX);
    y_wrap       = (y_q == Y_MAX);
    x_d          = x_q;
    y_d          = y_q;
    frame_tick_d = 1'b0;
    if (p_tick_q) begin
      x_d = x_wrap ? 10'd0 : x_q + 10'd1;
      if (x_wrap) begin
        y_d = y_wrap ? 10'd0 : y_q + 10'd1;
      end
      frame_tick_d = x_wrap && y_wrap;
    end
  end

  // Sync decode from the next coordinates so the pins move with x/y.
  always_comb begin
    hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
    vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
  end

  // State registers; reset clears counters and parks syncs inactive (high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q    <= 4'd0;
      p_tick_q     <= 1'b0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      p_tick_q     <= p_tick_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Output mapping; video_on is forced low while reset is held.
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign p_tick     = p_tick_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (x_q < X_VIS) && (y_q < Y_VIS) && reset;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: checks vga_sync against a clock-count model.
// Instance a uses the real 640x480 timing with CLK_DIV=4 (a few lines only);
// instance b uses a tiny raster with CLK_DIV=2 so whole frames, vsync and
// frame_tick fit in a short run. The model derives every output from the
// number of clock edges since reset release.
module tb_vga_sync;

  // Tiny raster for instance b: H_TOTAL=15, V_TOTAL=8, frame = 240 clks.
  localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVD = 4, BVF = 1, BVS = 2, BVB = 1;
  localparam int BDIV = 2;

  // Packed observation: {p_tick, frame_tick, hsync, vsync, video_on, x, y}
  localparam logic [24:0] RST_VEC = {5'b00110, 10'd0, 10'd0};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       hsync_a, vsync_a, video_on_a, p_tick_a, frame_tick_a;
  logic [9:0] x_a, y_a;
  logic       hsync_b, vsync_b, video_on_b, p_tick_b, frame_tick_b;
  logic [9:0] x_b, y_b;

  logic [24:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int k_a = 0;
  int k_b = 0;

  // clock / reset block
  always #5 clk = ~clk;

  vga_sync u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .hsync      (hsync_a),
    .vsync      (vsync_a),
    .video_on   (video_on_a),
    .p_tick     (p_tick_a),
    .x          (x_a),
    .y          (y_a),
    .frame_tick (frame_tick_a)
  );

  vga_sync #(
    .H_DISPLAY (BHD), .H_FRONT (BHF), .H_SYNC (BHS), .H_BACK (BHB),
    .V_DISPLAY (BVD), .V_FRONT (BVF), .V_SYNC (BVS), .V_BACK (BVB),
    .CLK_DIV   (BDIV)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .hsync      (hsync_b),
    .vsync      (vsync_b),
    .video_on   (video_on_b),
    .p_tick     (p_tick_b),
    .x          (x_b),
    .y          (y_b),
    .frame_tick (frame_tick_b)
  );

  wire [24:0] obs_a = {p_tick_a, frame_tick_a, hsync_a, vsync_a, video_on_a, x_a, y_a};
  wire [24:0] obs_b = {p_tick_b, frame_tick_b, hsync_b, vsync_b, video_on_b, x_b, y_b};

  // Expected outputs k clock edges after reset release.
  function automatic logic [24:0] model(input int k, input int div,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb);
    int ht, vt, ticks, px, py;
    logic p, f, h, v, vo;
    ht    = hd + hf + hs + hb;
    vt    = vd + vf + vs + vb;
    ticks = k / div;
    px    = ticks % ht;
    py    = (ticks / ht) % vt;
    p     = ((k % div) == div - 1);
    f     = (k > 0) && ((k % div) == 0) && (px == 0) && (py == 0);
    h     = !((px >= hd + hf) && (px < hd + hf + hs));
    v     = !((py >= vd + vf) && (py < vd + vf + vs));
    vo    = (px < hd) && (py < vd);
    return {p, f, h, v, vo, 10'(px), 10'(py)};
  endfunction

  function automatic logic [24:0] model_a(input int k);
    return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] model_b(input int k);
    return model(k, BDIV, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB);
  endfunction

  // scoreboard compare: pops the oldest expectation
  task automatic check(input string tag, input logic [24:0] obs);
    logic [24:0] exp_v;
    exp_v = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed pfhvv=%b x=%0d y=%0d, expected pfhvv=%b x=%0d y=%0d",
             tag, obs[24:20], obs[19:10], obs[9:0], exp_v[24:20], exp_v[19:10], exp_v[9:0]);
    end
  endtask

  // driver: advance instance a n clocks, checking every cycle
  task automatic run_a(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k_a++;
      exp_q.push_back(model_a(k_a));
      @(negedge clk);
      check(tag, obs_a);
    end
  endtask

  task automatic run_b(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k_b++;
      exp_q.push_back(model_b(k_b));
      @(negedge clk);
      check(tag, obs_b);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(RST_VEC);
    check("a_reset_state", obs_a);
    exp_q.push_back(RST_VEC);
    check("b_reset_state", obs_b);

    // release a between edges; first counting edge follows
    @(negedge clk);
    rst_a = 1'b1;
    k_a   = 0;
    #1;
    exp_q.push_back(model_a(0));
    check("a_release", obs_a);

    // first line, line wrap into y=1, up to x=700 inside the hsync pulse
    run_a(6000, "a_run1");

    // async reset mid hsync: no clock edge between drive and check
    rst_a = 1'b0;
    #1;
    exp_q.push_back(RST_VEC);
    check("a_async_rst", obs_a);
    repeat (2) @(negedge clk);
    exp_q.push_back(RST_VEC);
    check("a_rst_hold", obs_a);

    // release again: timing restarts from zero, run past one line wrap
    rst_a = 1'b1;
    k_a   = 0;
    #1;
    exp_q.push_back(model_a(0));
    check("a_rerelease", obs_a);
    run_a(3300, "a_run2");

    // instance b: small raster, CLK_DIV=2
    @(negedge clk);
    rst_b = 1'b1;
    k_b   = 0;
    #1;
    exp_q.push_back(model_b(0));
    check("b_release", obs_b);

    // x=11, y=6: inside both hsync and vsync pulses
    run_b(202, "b_run1");
    rst_b = 1'b0;
    #1;
    exp_q.push_back(RST_VEC);
    check("b_async_rst", obs_b);
    repeat (2) @(negedge clk);
    exp_q.push_back(RST_VEC);
    check("b_rst_hold", obs_b);

    // three full frames plus a little: frame_tick, vsync, wraps
    rst_b = 1'b1;
    k_b   = 0;
    #1;
    exp_q.push_back(model_b(0));
    check("b_rerelease", obs_b);
    run_b(3 * 240 + 10, "b_run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
